// File: rtl/ws281x_lane_encoder.sv
// Multi-lane WS281x encoder: pixel words in over valid/ready, lockstep pulse codes out.
// Define WS281X_LANE_GAP_EN to append a frame-latch low gap after the last word.
`timescale 1ns/1ps

module ws281x_lane_encoder #(
    parameter int CH     = 4,
    parameter int DATA_W = 24,
    parameter int CNT_W  = 8,
    parameter int GAP_W  = 16
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 word_vld_in,
    output logic                 word_rdy_out,
    input  logic [CH*DATA_W-1:0] word_data_in,
    input  logic                 word_last_in,
    input  logic [CNT_W-1:0]     t0h_cnt_in,
    input  logic [CNT_W-1:0]     t0l_cnt_in,
    input  logic [CNT_W-1:0]     t1h_cnt_in,
    input  logic [CNT_W-1:0]     t1l_cnt_in,
    input  logic [GAP_W-1:0]     gap_cnt_in,
    output logic [CH-1:0]        code_out,
    output logic                 busy_out,
    output logic                 frame_done_out
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PER_W = CNT_W + 1;

`ifdef WS281X_LANE_GAP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_BIT, ST_GAP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_BIT} state_t;
`endif

    state_t               state_q, state_d;
    logic [PER_W-1:0]     cnt_q, cnt_d;
    logic [PER_W-1:0]     per_q, per_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [CH*DATA_W-1:0] word_q, word_d;
    logic [CNT_W-1:0]     t0h_q, t0h_d;
    logic [CNT_W-1:0]     t1h_q, t1h_d;
    logic [CH-1:0]        code_q, code_d;
    logic                 done_q, done_d;
    logic                 rdy_en_q, rdy_en_d;

    logic [PER_W-1:0]     sum0, sum1, per_in;
    logic                 bit_end, word_end, rdy_raw, accept;

`ifdef WS281X_LANE_GAP_EN
    logic                 last_q, last_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [GAP_W-1:0]     gcnt_q, gcnt_d;
`else
    logic                 unused_gap;
    assign unused_gap = ^{word_last_in, gap_cnt_in};
`endif

    // Shared bit period, never zero so the counter always advances.
    always_comb begin
        sum0   = {1'b0, t0h_cnt_in} + {1'b0, t0l_cnt_in};
        sum1   = {1'b0, t1h_cnt_in} + {1'b0, t1l_cnt_in};
        per_in = (sum0 > sum1) ? sum0 : sum1;
        if (per_in == '0) begin
            per_in = PER_W'(1);
        end
    end

    assign bit_end  = (state_q == ST_BIT) && (cnt_q == per_q - PER_W'(1));
    assign word_end = bit_end && (bit_idx_q == '0);

`ifdef WS281X_LANE_GAP_EN
    assign rdy_raw = (state_q == ST_IDLE) || (word_end && !last_q);
`else
    assign rdy_raw = (state_q == ST_IDLE) || word_end;
`endif

    assign word_rdy_out = rdy_en_q && rdy_raw;
    assign accept       = word_vld_in && word_rdy_out;
    assign rdy_en_d     = 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        per_d     = per_q;
        bit_idx_d = bit_idx_q;
        word_d    = word_q;
        t0h_d     = t0h_q;
        t1h_d     = t1h_q;
        done_d    = 1'b0;
`ifdef WS281X_LANE_GAP_EN
        last_d    = last_q;
        gap_d     = gap_q;
        gcnt_d    = gcnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
            end
            ST_BIT: begin
                if (!bit_end) begin
                    cnt_d = cnt_q + PER_W'(1);
                end else begin
                    cnt_d = '0;
                    if (bit_idx_q != '0) begin
                        bit_idx_d = bit_idx_q - IDX_W'(1);
                    end else begin
`ifdef WS281X_LANE_GAP_EN
                        if (last_q) begin
                            state_d = ST_GAP;
                            gcnt_d  = '0;
                        end else begin
                            state_d = ST_IDLE;
                        end
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef WS281X_LANE_GAP_EN
            ST_GAP: begin
                if (gcnt_q == gap_q - GAP_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1);
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Acceptance overrides the end-of-word exit so words chain seamlessly.
        if (accept) begin
            state_d   = ST_BIT;
            cnt_d     = '0;
            bit_idx_d = IDX_W'(DATA_W - 1);
            word_d    = word_data_in;
            t0h_d     = t0h_cnt_in;
            t1h_d     = t1h_cnt_in;
            per_d     = per_in;
            done_d    = 1'b0;
`ifdef WS281X_LANE_GAP_EN
            last_d    = word_last_in;
            gap_d     = (gap_cnt_in == '0) ? GAP_W'(1) : gap_cnt_in;
`endif
        end
    end

    always_comb begin
        code_d = '0;
        if (state_q == ST_BIT) begin
            for (int c = 0; c < CH; c++) begin
                code_d[c] = word_q[c*DATA_W + int'(bit_idx_q)]
                          ? (cnt_q < {1'b0, t1h_q})
                          : (cnt_q < {1'b0, t0h_q});
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            per_q     <= PER_W'(1);
            bit_idx_q <= '0;
            word_q    <= '0;
            t0h_q     <= '0;
            t1h_q     <= '0;
            code_q    <= '0;
            done_q    <= 1'b0;
            rdy_en_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            bit_idx_q <= bit_idx_d;
            word_q    <= word_d;
            t0h_q     <= t0h_d;
            t1h_q     <= t1h_d;
            code_q    <= code_d;
            done_q    <= done_d;
            rdy_en_q  <= rdy_en_d;
        end
    end

`ifdef WS281X_LANE_GAP_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_q <= 1'b0;
            gap_q  <= GAP_W'(1);
            gcnt_q <= '0;
        end else begin
            last_q <= last_d;
            gap_q  <= gap_d;
            gcnt_q <= gcnt_d;
        end
    end
`endif

    assign code_out       = code_q;
    assign busy_out       = (state_q != ST_IDLE);
    assign frame_done_out = done_q;

endmodule

// File: tb/tb_ws281x_lane_encoder.sv
// Directed bench for ws281x_lane_encoder; expectations follow WS281X_LANE_GAP_EN.
`timescale 1ns/1ps

module tb_ws281x_lane_encoder;

    localparam int CH = 4;
    localparam int DW = 24;
    localparam int CW = 8;
    localparam int GW = 16;

    logic             clk_in = 1'b0;
    logic             rst_n_in = 1'b0;
    logic             word_vld_in = 1'b0;
    logic             word_rdy_out;
    logic [CH*DW-1:0] word_data_in = '0;
    logic             word_last_in = 1'b0;
    logic [CW-1:0]    t0h, t0l, t1h, t1l;
    logic [GW-1:0]    gap;
    logic [CH-1:0]    code_out;
    logic             busy_out;
    logic             frame_done_out;

    int n_vec = 0;
    int n_bad = 0;

    logic [CH-1:0] tr_code [0:1023];
    logic          tr_busy [0:1023];
    logic          tr_done [0:1023];

    int hand_l0 [24] = '{7,3,7,3,3,7,3,7, 3,3,3,3,3,3,3,3, 7,7,7,7,7,7,7,7};

    logic [CH*DW-1:0] w_a = {24'h0, 24'h0, 24'h0, 24'hA500FF};
    logic [CH*DW-1:0] w_b = {24'h5A5A5A, 24'h800001, 24'hFFFFFF, 24'h000000};
    logic [CH*DW-1:0] w_c = {24'hC3C3C3, 24'h0F0F0F, 24'h123456, 24'hF0E1D2};

    ws281x_lane_encoder #(.CH(CH), .DATA_W(DW), .CNT_W(CW), .GAP_W(GW)) dut (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .word_vld_in    (word_vld_in),
        .word_rdy_out   (word_rdy_out),
        .word_data_in   (word_data_in),
        .word_last_in   (word_last_in),
        .t0h_cnt_in     (t0h),
        .t0l_cnt_in     (t0l),
        .t1h_cnt_in     (t1h),
        .t1l_cnt_in     (t1l),
        .gap_cnt_in     (gap),
        .code_out       (code_out),
        .busy_out       (busy_out),
        .frame_done_out (frame_done_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_t(input int a, input int b, input int c,
                         input int d, input int g);
        t0h = CW'(a);
        t0l = CW'(b);
        t1h = CW'(c);
        t1l = CW'(d);
        gap = GW'(g);
    endtask

    // Returns just after the accepting edge (edge k + 1ns).
    task automatic accept(input logic [CH*DW-1:0] w, input logic last,
                          input bit hold);
        int n = 0;
        word_data_in = w;
        word_last_in = last;
        word_vld_in  = 1'b1;
        while (!word_rdy_out && n < 2000) begin
            @(negedge clk_in);
            n++;
        end
        chk("rdy_wait", word_rdy_out, 1);
        @(posedge clk_in);
        #1;
        if (!hold) word_vld_in = 1'b0;
    endtask

    // Sample t holds the outputs launched by edge k+1+t.
    task automatic capture(input int n, input int drop_t);
        @(negedge clk_in);
        for (int t = 0; t < n; t++) begin
            @(negedge clk_in);
            tr_code[t] = code_out;
            tr_busy[t] = busy_out;
            tr_done[t] = frame_done_out;
            if (t == drop_t) word_vld_in = 1'b0;
        end
    endtask

    function automatic int width(input int base, input int lane, input int per);
        int s = 0;
        for (int i = base; i < base + per; i++) s += int'(tr_code[i][lane]);
        return s;
    endfunction

    function automatic int first_done(input int n);
        for (int i = 0; i < n; i++) if (tr_done[i]) return i;
        return -1;
    endfunction

    function automatic int done_cnt(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += int'(tr_done[i]);
        return s;
    endfunction

    task automatic chk_word(input string tag, input logic [CH*DW-1:0] w,
                            input int base, input int per,
                            input int h0, input int h1);
        for (int c = 0; c < CH; c++) begin
            for (int n = 0; n < DW; n++) begin
                chk($sformatf("%s_l%0d_b%0d", tag, c, n),
                    width(base + n*per, c, per),
                    w[c*DW + DW-1-n] ? h1 : h0);
            end
        end
    endtask

    task automatic chk_hand(input string tag, input int base);
        for (int n = 0; n < DW; n++) begin
            chk($sformatf("%s_l0_b%0d", tag, n), width(base + n*12, 0, 12),
                hand_l0[n]);
            for (int c = 1; c < CH; c++) begin
                chk($sformatf("%s_l%0d_b%0d", tag, c, n),
                    width(base + n*12, c, 12), 3);
            end
        end
    endtask

    initial begin
        int hi;
        int exp_idx;
        set_t(3, 9, 7, 5, 50);

        #2;
        chk("rst_rdy", word_rdy_out, 0);
        chk("rst_code", code_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_done", frame_done_out, 0);
        repeat (3) @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk("rel_rdy", word_rdy_out, 1);
        @(negedge clk_in);

        // Single word, T=12.
        accept(w_a, 1'b0, 1'b0);
        chk("t1_busy_k", busy_out, 1);
        chk("t1_rdy_k", word_rdy_out, 0);
        capture(300, -1);
        chk_hand("t1", 0);
        chk("t1_busy_last", tr_busy[286], 1);
        chk("t1_busy_idle", tr_busy[287], 0);
`ifdef WS281X_LANE_GAP_EN
        chk("t1_done_cnt", done_cnt(300), 0);
`else
        chk("t1_done_cnt", done_cnt(300), 1);
        chk("t1_done_idx", first_done(300), 287);
`endif

        // Two chained words, the second closes the frame.
        accept(w_a, 1'b0, 1'b1);
        word_data_in = w_b;
        word_last_in = 1'b1;
        capture(700, 287);
        chk_hand("t2a", 0);
        chk_word("t2b", w_b, 288, 12, 3, 7);
        hi = 0;
        for (int i = 0; i < 575; i++) hi += int'(tr_busy[i]);
        chk("t2_busy_words", hi, 575);
        hi = 0;
        for (int i = 576; i < 626; i++) hi += int'(tr_code[i] != '0);
        chk("t2_gap_highs", hi, 0);
`ifdef WS281X_LANE_GAP_EN
        exp_idx = 625;
        chk("t2_busy_gap", tr_busy[600], 1);
`else
        exp_idx = 575;
        chk("t2_busy_gap", tr_busy[600], 0);
`endif
        chk("t2_done_idx", first_done(700), exp_idx);
        chk("t2_done_cnt", done_cnt(700), 1);
        chk("t2_busy_end", tr_busy[exp_idx], 0);
        chk("t2_busy_pre", tr_busy[exp_idx-1], 1);

        // Zero timing: T=1, all low, zero gap.
        set_t(0, 0, 0, 0, 0);
        accept({CH*DW{1'b1}}, 1'b1, 1'b0);
        capture(40, -1);
        hi = 0;
        for (int i = 0; i < 40; i++) hi += int'(tr_code[i] != '0);
        chk("t3_highs", hi, 0);
`ifdef WS281X_LANE_GAP_EN
        exp_idx = 24;
`else
        exp_idx = 23;
`endif
        chk("t3_done_idx", first_done(40), exp_idx);
        chk("t3_done_cnt", done_cnt(40), 1);
        chk("t3_busy_pre", tr_busy[exp_idx-1], 1);
        chk("t3_busy_end", tr_busy[exp_idx], 0);

        // Timing changed mid-word applies only from the next word.
        set_t(3, 9, 7, 5, 50);
        accept(w_c, 1'b0, 1'b0);
        set_t(1, 1, 2, 2, 50);
        capture(300, -1);
        chk_word("t4a", w_c, 0, 12, 3, 7);
        chk("t4a_busy_end", tr_busy[287], 0);
        chk("t4a_busy_pre", tr_busy[286], 1);
        accept(w_c, 1'b0, 1'b0);
        capture(110, -1);
        chk_word("t4b", w_c, 0, 4, 1, 2);
        chk("t4b_busy_end", tr_busy[95], 0);
        chk("t4b_busy_pre", tr_busy[94], 1);

        // Reset pulse during bit 10, then a clean word.
        set_t(3, 9, 7, 5, 50);
        accept(w_a, 1'b0, 1'b0);
        repeat (159) @(negedge clk_in);
        chk("t5_pre_code", code_out, 4'hF);
        rst_n_in = 1'b0;
        #1;
        chk("t5_code", code_out, 0);
        chk("t5_busy", busy_out, 0);
        chk("t5_rdy", word_rdy_out, 0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        #1;
        chk("t5_rdy_rel", word_rdy_out, 0);
        @(posedge clk_in);
        #1;
        chk("t5_rdy_edge", word_rdy_out, 1);
        chk("t5_busy_edge", busy_out, 0);
        chk("t5_code_edge", code_out, 0);
        @(negedge clk_in);
        accept(w_a, 1'b0, 1'b0);
        capture(300, -1);
        chk_hand("t5", 0);
        chk("t5_busy_end", tr_busy[287], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
